// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding instruction-memory
// request at a time, parks a returned word while decode is stalled, and drives
// the IF/ID pipeline register. Branch redirects from execute use an epoch tag so
// that a response belonging to a squashed request is recognised and dropped.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        fetch_write,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        fetch_busy
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]      state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic            epoch, epoch_d;
  logic            req_epoch, req_epoch_d;
  logic [XLEN-1:0] hold_buf, hold_buf_d;
  logic            if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_d;
  logic [XLEN-1:0] if_id_instruction_d;

  logic            handshake;
  logic            resp_match;
  logic            deliver;
  logic            deliver_now;
  logic [XLEN-1:0] deliver_word;

  // Request interface and busy flag decode straight from the state register;
  // the request is masked while reset is held so nothing is accepted then.
  assign imem_req_valid = (state == S_REQ) & ~reset;
  assign imem_req_addr  = pc;
  assign fetch_busy     = (state != S_REQ);

  assign handshake  = imem_req_valid & imem_req_ready;
  assign resp_match = imem_resp_valid & (req_epoch == epoch);
  assign deliver    = pc_write & fetch_write & ~flush;

  // Next-state, PC, epoch, holding buffer and IF/ID computation.
  always_comb begin
    state_d             = state;
    pc_d                = pc;
    epoch_d             = epoch;
    req_epoch_d         = req_epoch;
    hold_buf_d          = hold_buf;
    if_id_valid_d       = if_id_valid;
    if_id_pc_d          = if_id_pc;
    if_id_instruction_d = if_id_instruction;
    deliver_now         = 1'b0;
    deliver_word        = NOP_INSTR;

    case (state)
      S_REQ: begin
        if (handshake) begin
          req_epoch_d = epoch;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (!resp_match) begin
            state_d = S_REQ;
          end else if (deliver) begin
            deliver_now  = 1'b1;
            deliver_word = imem_resp_data;
            state_d      = S_REQ;
          end else if (!flush) begin
            hold_buf_d = imem_resp_data;
            state_d    = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (deliver) begin
          deliver_now  = 1'b1;
          deliver_word = hold_buf;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // IF/ID update: new instruction, bubble, or hold under stall.
    if (deliver_now) begin
      if_id_valid_d       = 1'b1;
      if_id_pc_d          = pc;
      if_id_instruction_d = deliver_word;
      pc_d                = pc + XLEN'(4);
    end else if (fetch_write) begin
      if_id_valid_d       = 1'b0;
      if_id_instruction_d = NOP_INSTR;
    end

    // Redirect wins over everything. A request still in flight (or accepted
    // this very cycle) gets a new epoch so its response is recognised as stale;
    // a response landing in the flush cycle itself is simply consumed.
    if (flush) begin
      pc_d                = flush_target & ~XLEN'(3);
      if_id_valid_d       = 1'b0;
      if_id_instruction_d = NOP_INSTR;
      if ((state == S_WAIT && !imem_resp_valid) || (state == S_REQ && handshake)) begin
        epoch_d = ~epoch;
        state_d = S_WAIT;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  // State and pipeline register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_REQ;
      pc                <= RESET_PC;
      epoch             <= 1'b0;
      req_epoch         <= 1'b0;
      hold_buf          <= NOP_INSTR;
      if_id_valid       <= 1'b0;
      if_id_pc          <= '0;
      if_id_instruction <= NOP_INSTR;
    end else begin
      state             <= state_d;
      pc                <= pc_d;
      epoch             <= epoch_d;
      req_epoch         <= req_epoch_d;
      hold_buf          <= hold_buf_d;
      if_id_valid       <= if_id_valid_d;
      if_id_pc          <= if_id_pc_d;
      if_id_instruction <= if_id_instruction_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that receives the stall controls from the hazard detection unit (pc_write, fetch_write) and the branch redirect from execute. It owns the PC, issues requests to instruction memory over a valid/ready request and valid response interface, and keeps one instruction in a holding buffer while decode is stalled. It drives the IF/ID pipeline register consumed by decode and by the hazard detection unit.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word driven into IF/ID on bubble or flush (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
pc_write  in  1  from hazard unit; 0 = PC must not advance
fetch_write  in  1  from hazard unit; 0 = IF/ID must hold
flush  in  1  taken branch or jump from execute
flush_target  in  32  redirect address
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  request address; word aligned
imem_resp_valid  in  1  response data valid; one response per accepted request; minimum 1 cycle after acceptance
imem_resp_data  in  32  instruction word
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  32  PC of the IF/ID instruction
if_id_instruction  out  32  IF/ID instruction word
fetch_busy  out  1  request outstanding or holding buffer full

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, state=S_REQ, epoch=0, holding buffer empty, if_id_valid=0, if_id_pc=0, if_id_instruction=NOP_INSTR, imem_req_valid=0 during the reset cycle. The first request is issued the cycle after reset deasserts. Reset asserted mid-transaction abandons all state. Any response arriving after reset is ignored until a new request is accepted.
- At most one outstanding request. Each request is tagged with the epoch value at acceptance (req_epoch).
- deliver = pc_write & fetch_write & ~flush.
- S_REQ: imem_req_valid=1, imem_req_addr=pc. Valid and address stay stable until ready. On valid&ready: req_epoch<=epoch, go to S_WAIT.
- S_WAIT: imem_req_valid=0.
  - On resp_valid with req_epoch!=epoch: drop the response, go to S_REQ.
  - On a matching response with deliver=1: IF/ID<={1,pc,data}, pc<=pc+4, go to S_REQ. The next request is issued the following cycle.
  - On a matching response with deliver=0 and no flush: store the word in the holding buffer, go to S_FULL.
- S_FULL: imem_req_valid=0. On deliver: IF/ID<={1,pc,buffer}, pc<=pc+4, buffer empty, go to S_REQ.
- IF/ID when no instruction is delivered:
  - fetch_write=1: if_id_valid<=0, if_id_instruction<=NOP_INSTR, if_id_pc unchanged.
  - fetch_write=0: all IF/ID fields hold.
- Flush has highest priority over stall and delivery:
  - pc<=flush_target with bits[1:0] forced to 0.
  - if_id_valid<=0, if_id_instruction<=NOP_INSTR, even if fetch_write=0.
  - Holding buffer discarded.
  - From S_FULL or S_REQ with no handshake that cycle: go to S_REQ.
  - From S_WAIT, or S_REQ with a handshake in the same cycle: toggle epoch, go to S_WAIT. The stale response is dropped when it arrives.
  - A response arriving in the flush cycle is discarded.
- fetch_busy = (state!=S_REQ).
- pc increments wrap modulo 2^32.

Test Plan:
- Reset, then memory always ready with 1-cycle latency returning addr^32'hA5A5_0000 -> requests go to 0x0, 0x4, 0x8. The IF/ID sequence is pc 0x0, 0x4, 0x8 with matching data, and valid is 0 on the bubble cycle between instructions.
- With an instruction from 0x4 in IF/ID, hold pc_write=fetch_write=0 for 3 cycles while the 0x8 response returns -> IF/ID holds 0x4, state is S_FULL, no new request. Release -> IF/ID gets 0x8 next edge and a request for 0xC issues the following cycle.
- Request 0x10 outstanding, 4-cycle latency, flush=1 with target 0x200 in cycle 1 -> IF/ID becomes NOP/valid=0. The 0x10 response is dropped, the next request is 0x200, and 0x10 never reaches IF/ID.
- imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1 and imem_req_addr stays stable. A flush to 0x103 during the stall -> address changes to 0x100.
- Flush with fetch_write=0 while in S_FULL -> buffer discarded, IF/ID valid=0, next request is flush_target.
- Assert reset while in S_WAIT, then deliver a late response -> the response is ignored, IF/ID valid=0, and the first request after reset goes to RESET_PC.
